// File: rtl/fetch_debug_ctrl_if.sv
// Bundle between the UART receiver, the fetch/pipeline top and the debug sequencer.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface fetch_debug_ctrl_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 7
);
    logic [7:0]         rx_data_i;
    logic               rx_valid_i;
    logic               halt_i;
    logic               en_write_o;
    logic [NB_ADDR-1:0] addr_write_o;
    logic [NB_DATA-1:0] data_write_o;
    logic               en_read_o;
    logic               cpu_enable_o;
    logic               cpu_reset_o;
    logic               overflow_o;
    logic [2:0]         state_o;

    modport master (
        input  rx_data_i, rx_valid_i, halt_i,
        output en_write_o, addr_write_o, data_write_o, en_read_o,
               cpu_enable_o, cpu_reset_o, overflow_o, state_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, halt_i,
        input  en_write_o, addr_write_o, data_write_o, en_read_o,
               cpu_enable_o, cpu_reset_o, overflow_o, state_o
    );
endinterface

// File: rtl/fetch_debug_ctrl.sv
// Debug sequencer: loads instruction memory from a UART byte stream, then runs
// the pipeline continuously or one cycle per 'N' command.
module fetch_debug_ctrl #(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_ADDR   = 7,
    parameter int                 ADDR_INC  = 4,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic              clock_i,
    input  logic              reset_i,
    fetch_debug_ctrl_if.master bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_LOADED = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_STEP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_RET  = 8'h52;

    localparam int                 NB_BYTES      = NB_DATA / 8;
    localparam int                 NB_CNT        = $clog2(NB_BYTES);
    localparam logic [NB_CNT-1:0]  LAST_BYTE     = NB_CNT'(NB_BYTES - 1);
    localparam int                 LAST_ADDR_INT = (1 << NB_ADDR) - ADDR_INC;
    localparam logic [NB_ADDR-1:0] LAST_ADDR     = NB_ADDR'(LAST_ADDR_INT);
    localparam logic [NB_ADDR-1:0] ADDR_STEP     = NB_ADDR'(ADDR_INC);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [NB_CNT-1:0]  byte_cnt;
    logic [NB_ADDR-1:0] addr;
    logic [NB_DATA-1:0] asm_word;
    logic [NB_DATA-1:0] next_word;
    logic               en_write;
    logic [NB_ADDR-1:0] wr_addr;
    logic [NB_DATA-1:0] wr_data;
    logic               cpu_en;
    logic               cpu_rst;
    logic               overflow;

    logic cmd_load, cmd_cont, cmd_step, cmd_next, cmd_ret;
    logic enter_load, start_cpu, step_fire, word_done, overflow_set;

    assign cmd_load = bus.rx_valid_i && (bus.rx_data_i == CMD_LOAD);
    assign cmd_cont = bus.rx_valid_i && (bus.rx_data_i == CMD_CONT);
    assign cmd_step = bus.rx_valid_i && (bus.rx_data_i == CMD_STEP);
    assign cmd_next = bus.rx_valid_i && (bus.rx_data_i == CMD_NEXT);
    assign cmd_ret  = bus.rx_valid_i && (bus.rx_data_i == CMD_RET);

    assign next_word    = {asm_word[NB_DATA-9:0], bus.rx_data_i};
    assign word_done    = (state == ST_LOAD) && bus.rx_valid_i && (byte_cnt == LAST_BYTE);
    // The memory-full check looks at the write being issued this cycle, so the
    // last slot is still written before the load is abandoned.
    assign overflow_set = (state == ST_LOAD) && en_write &&
                          (wr_data != HALT_WORD) && (wr_addr == LAST_ADDR);

    always_comb begin
        state_nxt  = state;
        enter_load = 1'b0;
        start_cpu  = 1'b0;
        step_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_load) begin
                    state_nxt  = ST_LOAD;
                    enter_load = 1'b1;
                end
            end
            ST_LOAD: begin
                if (en_write && (wr_data == HALT_WORD)) begin
                    state_nxt = ST_LOADED;
                end else if (overflow_set) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOADED: begin
                if (cmd_cont) begin
                    state_nxt = ST_RUN;
                    start_cpu = 1'b1;
                end else if (cmd_step) begin
                    state_nxt = ST_STEP;
                    start_cpu = 1'b1;
                end else if (cmd_ret) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.halt_i) state_nxt = ST_DONE;
            end
            // A halt retiring in the same cycle as 'N' takes priority over the step.
            ST_STEP: begin
                if (bus.halt_i) begin
                    state_nxt = ST_DONE;
                end else if (cmd_next) begin
                    step_fire = 1'b1;
                end else if (cmd_ret) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (cmd_ret) begin
                    state_nxt = ST_IDLE;
                end else if (cmd_load) begin
                    state_nxt  = ST_LOAD;
                    enter_load = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            addr     <= '0;
            asm_word <= '0;
            en_write <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_en   <= 1'b0;
            cpu_rst  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            en_write <= word_done;
            cpu_rst  <= start_cpu;
            cpu_en   <= ((state == ST_RUN) && !bus.halt_i) || step_fire;
            if (enter_load) begin
                addr     <= '0;
                byte_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                if (overflow_set) overflow <= 1'b1;
                if ((state == ST_LOAD) && bus.rx_valid_i) begin
                    asm_word <= next_word;
                    byte_cnt <= byte_cnt + 1'b1;
                end
                // The write is staged in its own register so capture of the next word can continue.
                if (word_done) begin
                    wr_data <= next_word;
                    wr_addr <= addr;
                    addr    <= addr + ADDR_STEP;
                end
            end
        end
    end

    assign bus.en_write_o   = en_write;
    assign bus.addr_write_o = wr_addr;
    assign bus.data_write_o = wr_data;
    assign bus.en_read_o    = (state != ST_LOAD);
    assign bus.cpu_enable_o = cpu_en;
    assign bus.cpu_reset_o  = cpu_rst;
    assign bus.overflow_o   = overflow;
    assign bus.state_o      = state;

endmodule

// File: tb/tb_fetch_debug_ctrl.sv
// Bench for fetch_debug_ctrl: directed scenarios followed by random byte/halt
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_fetch_debug_ctrl;

    localparam int          NB_DATA   = 32;
    localparam int          NB_ADDR   = 7;
    localparam int          ADDR_INC  = 4;
    localparam logic [31:0] HALT      = 32'hFFFFFFFF;
    localparam int          LAST_ADDR = (1 << NB_ADDR) - ADDR_INC;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;

    fetch_debug_ctrl_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

    fetch_debug_ctrl #(
        .NB_DATA  (NB_DATA),
        .NB_ADDR  (NB_ADDR),
        .ADDR_INC (ADDR_INC),
        .HALT_WORD(HALT)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .bus    (bus.master)
    );

    always #5 clock_i = ~clock_i;

    int checkCount = 0;
    int errCount   = 0;

    // Reference model: mode numbers are the debug values seen on state_o.
    int          mMode;
    logic [7:0]  mBytes[$];
    int          mWordCnt;
    bit          mWrDue;
    int          mWrAddr;
    logic [31:0] mWrData;
    bit          mOvf, mCpuRst, mCpuEn;

    int          wrAddrLog[$];
    logic [31:0] wrDataLog[$];
    int          enCount;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mMode = 0; mBytes.delete(); mWordCnt = 0;
        mWrDue = 0; mWrAddr = 0; mWrData = '0;
        mOvf = 0; mCpuRst = 0; mCpuEn = 0;
    endtask

    task automatic modelEnterLoad();
        mMode = 1; mBytes.delete(); mWordCnt = 0; mOvf = 0;
    endtask

    task automatic modelStep(input bit valid, input logic [7:0] data, input bit halt);
        bit          nWr = 0, nRst = 0, nEn = 0;
        int          nWrAddr = mWrAddr;
        logic [31:0] nWrData = mWrData;
        logic [31:0] w;
        case (mMode)
            0: if (valid && data == 8'h4C) modelEnterLoad();
            1: begin
                if (mWrDue && mWrData == HALT) mMode = 2;
                else if (mWrDue && mWrAddr == LAST_ADDR) begin mMode = 0; mOvf = 1; end
                else if (valid) begin
                    mBytes.push_back(data);
                    if (mBytes.size() == 4) begin
                        w = 0;
                        foreach (mBytes[i]) w = w * 256 + 32'(mBytes[i]);
                        nWr = 1; nWrData = w; nWrAddr = mWordCnt * ADDR_INC;
                        mWordCnt++;
                        mBytes.delete();
                    end
                end
            end
            2: begin
                if (valid && data == 8'h43) begin mMode = 3; nRst = 1; end
                else if (valid && data == 8'h53) begin mMode = 4; nRst = 1; end
                else if (valid && data == 8'h52) mMode = 0;
            end
            3: if (halt) mMode = 5; else nEn = 1;
            4: begin
                if (halt) mMode = 5;
                else if (valid && data == 8'h4E) nEn = 1;
                else if (valid && data == 8'h52) mMode = 0;
            end
            5: begin
                if (valid && data == 8'h52) mMode = 0;
                else if (valid && data == 8'h4C) modelEnterLoad();
            end
            default: mMode = 0;
        endcase
        mWrDue = nWr; mWrAddr = nWrAddr; mWrData = nWrData;
        mCpuRst = nRst; mCpuEn = nEn;
    endtask

    task automatic compareAll();
        checkOutput("state", 32'(bus.state_o), 32'(mMode));
        checkOutput("en_read", 32'(bus.en_read_o), 32'(mMode != 1));
        checkOutput("cpu_enable", 32'(bus.cpu_enable_o), 32'(mCpuEn));
        checkOutput("cpu_reset", 32'(bus.cpu_reset_o), 32'(mCpuRst));
        checkOutput("en_write", 32'(bus.en_write_o), 32'(mWrDue));
        checkOutput("overflow", 32'(bus.overflow_o), 32'(mOvf));
        if (mWrDue) begin
            checkOutput("wr_addr", 32'(bus.addr_write_o), 32'(mWrAddr));
            checkOutput("wr_data", bus.data_write_o, mWrData);
        end
        if (bus.en_write_o) begin
            wrAddrLog.push_back(int'(bus.addr_write_o));
            wrDataLog.push_back(bus.data_write_o);
        end
        if (bus.cpu_enable_o) enCount++;
    endtask

    // One clock: drive at the falling edge, let the rising edge act, check at the next falling edge.
    task automatic applyStimulus(input bit valid, input logic [7:0] data, input bit halt);
        bus.rx_valid_i = valid;
        bus.rx_data_i  = data;
        bus.halt_i     = halt;
        modelStep(valid, data, halt);
        @(posedge clock_i);
        @(negedge clock_i);
        bus.rx_valid_i = 1'b0;
        bus.halt_i     = 1'b0;
        compareAll();
    endtask

    task automatic doReset();
        reset_i        = 1'b1;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        bus.halt_i     = 1'b0;
        modelReset();
        @(posedge clock_i);
        @(negedge clock_i);
        compareAll();
        reset_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, w[i*8 +: 8], 1'b0);
    endtask

    task automatic clearLogs();
        wrAddrLog.delete();
        wrDataLog.delete();
        enCount = 0;
    endtask

    function automatic logic [7:0] pickByte(input int mode);
        logic [7:0] cmds [7];
        int r;
        cmds = '{8'h4C, 8'h43, 8'h53, 8'h4E, 8'h52, 8'h41, 8'h00};
        if (mode == 1) begin
            r = $urandom_range(0, 9);
            if (r < 5) return 8'hFF;
            if (r < 6) return 8'h00;
            return 8'($urandom);
        end
        r = $urandom_range(0, 7);
        if (r == 7) return 8'($urandom);
        return cmds[r];
    endfunction

    initial begin
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        bus.halt_i     = 1'b0;
        clearLogs();
        @(negedge clock_i);
        doReset();

        $display("[TB] load three words back to back");
        clearLogs();
        applyStimulus(1'b1, 8'h4C, 1'b0);
        sendWord(32'h20010005);
        sendWord(32'h20020007);
        sendWord(HALT);
        idle(3);
        checkOutput("load_write_count", 32'(wrAddrLog.size()), 32'd3);
        if (wrAddrLog.size() == 3) begin
            checkOutput("load_addr2", 32'(wrAddrLog[2]), 32'd8);
            checkOutput("load_data0", wrDataLog[0], 32'h20010005);
            checkOutput("load_data1", wrDataLog[1], 32'h20020007);
        end
        checkOutput("loaded_state", 32'(bus.state_o), 32'd2);

        $display("[TB] continuous run until halt");
        applyStimulus(1'b1, 8'h43, 1'b0);
        idle(20);
        applyStimulus(1'b1, 8'h4E, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(3);
        checkOutput("run_done_state", 32'(bus.state_o), 32'd5);

        $display("[TB] step mode");
        applyStimulus(1'b1, 8'h4C, 1'b0);
        sendWord(32'h12345678);
        sendWord(HALT);
        idle(2);
        applyStimulus(1'b1, 8'h53, 1'b0);
        clearLogs();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 8'h4E, 1'b0);
            idle(9);
        end
        applyStimulus(1'b1, 8'h4E, 1'b1);
        idle(2);
        checkOutput("step_pulse_count", 32'(enCount), 32'd3);
        checkOutput("step_done_state", 32'(bus.state_o), 32'd5);

        $display("[TB] overflow load");
        applyStimulus(1'b1, 8'h4C, 1'b0);
        clearLogs();
        for (int k = 0; k < 32; k++) sendWord(32'h00000000);
        idle(4);
        checkOutput("ovf_write_count", 32'(wrAddrLog.size()), 32'd32);
        if (wrAddrLog.size() > 0)
            checkOutput("ovf_last_addr", 32'(wrAddrLog[wrAddrLog.size()-1]), 32'(LAST_ADDR));
        checkOutput("ovf_flag", 32'(bus.overflow_o), 32'd1);

        $display("[TB] reset during load, invalid commands");
        applyStimulus(1'b1, 8'h41, 1'b0);
        applyStimulus(1'b1, 8'h4C, 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 8'(8'h10 + k), 1'b0);
        doReset();
        clearLogs();
        applyStimulus(1'b1, 8'h4C, 1'b0);
        sendWord(HALT);
        idle(2);
        checkOutput("rst_write_count", 32'(wrAddrLog.size()), 32'd1);
        if (wrAddrLog.size() == 1) begin
            checkOutput("rst_write_addr", 32'(wrAddrLog[0]), 32'd0);
            checkOutput("rst_write_data", wrDataLog[0], HALT);
        end
        applyStimulus(1'b1, 8'h41, 1'b0);
        idle(2);

        $display("[TB] random traffic");
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 9) < 6, pickByte(mMode), $urandom_range(0, 11) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
        $finish;
    end

endmodule
